// File: rtl/axi_arbiter.sv
// axi_arbiter: two-to-one AXI4 master arbiter, one outstanding transaction.
// Master 0 is the instruction fetch unit and master 1 is the load/store unit.
// The winning master is wired straight through to the s_* port until its
// transaction finishes: a read ends on the last R beat, a write ends on B.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   m0_*, m1_*        AXI4 slave-side ports facing each master (AW/W/B/AR/R)
//   s_*               AXI4 master-side port facing the downstream slave
//   busy              registered, high whenever a transaction is owned
//
// Build option:
//   AXI_ARB_RR_EN     defined: round-robin on ties (a `last` register is kept).
//                     undefined: fixed priority, master 1 wins every tie.
module axi_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    // master 0 (IFU)
    input  logic              m0_awvalid,
    input  logic [ADDR_W-1:0] m0_awaddr,
    input  logic [ID_W-1:0]   m0_awid,
    input  logic [7:0]        m0_awlen,
    input  logic [2:0]        m0_awsize,
    input  logic [1:0]        m0_awburst,
    output logic              m0_awready,
    input  logic              m0_wvalid,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    input  logic              m0_wlast,
    output logic              m0_wready,
    output logic              m0_bvalid,
    output logic [1:0]        m0_bresp,
    output logic [ID_W-1:0]   m0_bid,
    input  logic              m0_bready,
    input  logic              m0_arvalid,
    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic [ID_W-1:0]   m0_arid,
    input  logic [7:0]        m0_arlen,
    input  logic [2:0]        m0_arsize,
    input  logic [1:0]        m0_arburst,
    output logic              m0_arready,
    output logic              m0_rvalid,
    output logic [1:0]        m0_rresp,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_rlast,
    output logic [ID_W-1:0]   m0_rid,
    input  logic              m0_rready,
    // master 1 (LSU)
    input  logic              m1_awvalid,
    input  logic [ADDR_W-1:0] m1_awaddr,
    input  logic [ID_W-1:0]   m1_awid,
    input  logic [7:0]        m1_awlen,
    input  logic [2:0]        m1_awsize,
    input  logic [1:0]        m1_awburst,
    output logic              m1_awready,
    input  logic              m1_wvalid,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    input  logic              m1_wlast,
    output logic              m1_wready,
    output logic              m1_bvalid,
    output logic [1:0]        m1_bresp,
    output logic [ID_W-1:0]   m1_bid,
    input  logic              m1_bready,
    input  logic              m1_arvalid,
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic [ID_W-1:0]   m1_arid,
    input  logic [7:0]        m1_arlen,
    input  logic [2:0]        m1_arsize,
    input  logic [1:0]        m1_arburst,
    output logic              m1_arready,
    output logic              m1_rvalid,
    output logic [1:0]        m1_rresp,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_rlast,
    output logic [ID_W-1:0]   m1_rid,
    input  logic              m1_rready,
    // downstream slave
    output logic              s_awvalid,
    output logic [ADDR_W-1:0] s_awaddr,
    output logic [ID_W-1:0]   s_awid,
    output logic [7:0]        s_awlen,
    output logic [2:0]        s_awsize,
    output logic [1:0]        s_awburst,
    input  logic              s_awready,
    output logic              s_wvalid,
    output logic [DATA_W-1:0] s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    output logic              s_wlast,
    input  logic              s_wready,
    input  logic              s_bvalid,
    input  logic [1:0]        s_bresp,
    input  logic [ID_W-1:0]   s_bid,
    output logic              s_bready,
    output logic              s_arvalid,
    output logic [ADDR_W-1:0] s_araddr,
    output logic [ID_W-1:0]   s_arid,
    output logic [7:0]        s_arlen,
    output logic [2:0]        s_arsize,
    output logic [1:0]        s_arburst,
    input  logic              s_arready,
    input  logic              s_rvalid,
    input  logic [1:0]        s_rresp,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic              s_rlast,
    input  logic [ID_W-1:0]   s_rid,
    output logic              s_rready,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t state;
    logic   owner;
    logic   req0, req1, sel, sel_rd;

    assign req0 = m0_arvalid | m0_awvalid;
    assign req1 = m1_arvalid | m1_awvalid;

`ifdef AXI_ARB_RR_EN
    logic last;
    // On a tie the master that did not own the previous transaction wins.
    assign sel = (req0 & req1) ? ~last : req1;
`else
    assign sel = req1;
`endif

    // A master raising both AR and AW gets its read served first.
    assign sel_rd = sel ? m1_arvalid : m0_arvalid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            owner <= 1'b0;
            busy  <= 1'b0;
`ifdef AXI_ARB_RR_EN
            last  <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: if (req0 | req1) begin
                    owner <= sel;
                    state <= sel_rd ? RD : WR;
                    busy  <= 1'b1;
                end
                RD: if (s_rvalid & s_rready & s_rlast) begin
                    state <= IDLE;
                    busy  <= 1'b0;
`ifdef AXI_ARB_RR_EN
                    last  <= owner;
`endif
                end
                WR: if (s_bvalid & s_bready) begin
                    state <= IDLE;
                    busy  <= 1'b0;
`ifdef AXI_ARB_RR_EN
                    last  <= owner;
`endif
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Channel routing. Everything not connected to the owner in the current
    // state reads as zero, including payload, so idle buses are quiet.
    always_comb begin
        s_awvalid = 1'b0; s_awaddr = '0; s_awid = '0; s_awlen = '0;
        s_awsize  = '0;   s_awburst = '0;
        s_wvalid  = 1'b0; s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0;
        s_bready  = 1'b0;
        s_arvalid = 1'b0; s_araddr = '0; s_arid = '0; s_arlen = '0;
        s_arsize  = '0;   s_arburst = '0;
        s_rready  = 1'b0;
        m0_awready = 1'b0; m0_wready = 1'b0; m0_arready = 1'b0;
        m0_bvalid = 1'b0; m0_bresp = '0; m0_bid = '0;
        m0_rvalid = 1'b0; m0_rresp = '0; m0_rdata = '0; m0_rlast = 1'b0; m0_rid = '0;
        m1_awready = 1'b0; m1_wready = 1'b0; m1_arready = 1'b0;
        m1_bvalid = 1'b0; m1_bresp = '0; m1_bid = '0;
        m1_rvalid = 1'b0; m1_rresp = '0; m1_rdata = '0; m1_rlast = 1'b0; m1_rid = '0;
        case (state)
            RD: begin
                s_arvalid = owner ? m1_arvalid : m0_arvalid;
                s_araddr  = owner ? m1_araddr  : m0_araddr;
                s_arid    = owner ? m1_arid    : m0_arid;
                s_arlen   = owner ? m1_arlen   : m0_arlen;
                s_arsize  = owner ? m1_arsize  : m0_arsize;
                s_arburst = owner ? m1_arburst : m0_arburst;
                s_rready  = owner ? m1_rready  : m0_rready;
                if (owner) begin
                    m1_arready = s_arready; m1_rvalid = s_rvalid; m1_rresp = s_rresp;
                    m1_rdata = s_rdata; m1_rlast = s_rlast; m1_rid = s_rid;
                end else begin
                    m0_arready = s_arready; m0_rvalid = s_rvalid; m0_rresp = s_rresp;
                    m0_rdata = s_rdata; m0_rlast = s_rlast; m0_rid = s_rid;
                end
            end
            WR: begin
                s_awvalid = owner ? m1_awvalid : m0_awvalid;
                s_awaddr  = owner ? m1_awaddr  : m0_awaddr;
                s_awid    = owner ? m1_awid    : m0_awid;
                s_awlen   = owner ? m1_awlen   : m0_awlen;
                s_awsize  = owner ? m1_awsize  : m0_awsize;
                s_awburst = owner ? m1_awburst : m0_awburst;
                s_wvalid  = owner ? m1_wvalid  : m0_wvalid;
                s_wdata   = owner ? m1_wdata   : m0_wdata;
                s_wstrb   = owner ? m1_wstrb   : m0_wstrb;
                s_wlast   = owner ? m1_wlast   : m0_wlast;
                s_bready  = owner ? m1_bready  : m0_bready;
                if (owner) begin
                    m1_awready = s_awready; m1_wready = s_wready;
                    m1_bvalid = s_bvalid; m1_bresp = s_bresp; m1_bid = s_bid;
                end else begin
                    m0_awready = s_awready; m0_wready = s_wready;
                    m0_bvalid = s_bvalid; m0_bresp = s_bresp; m0_bid = s_bid;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_arbiter.sv
// Self-checking bench for axi_arbiter: two master drivers, a small slave
// model, and a scoreboard of expected grants, read beats, write data and
// write responses.
module tb_axi_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic m0_awvalid, m0_awready, m0_wvalid, m0_wready, m0_wlast, m0_bvalid, m0_bready;
    logic m0_arvalid, m0_arready, m0_rvalid, m0_rlast, m0_rready;
    logic [31:0] m0_awaddr, m0_araddr;
    logic [3:0]  m0_awid, m0_arid, m0_bid, m0_rid;
    logic [7:0]  m0_awlen, m0_arlen, m0_wstrb;
    logic [2:0]  m0_awsize, m0_arsize;
    logic [1:0]  m0_awburst, m0_arburst, m0_bresp, m0_rresp;
    logic [63:0] m0_wdata, m0_rdata;
    logic m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_wlast, m1_bvalid, m1_bready;
    logic m1_arvalid, m1_arready, m1_rvalid, m1_rlast, m1_rready;
    logic [31:0] m1_awaddr, m1_araddr;
    logic [3:0]  m1_awid, m1_arid, m1_bid, m1_rid;
    logic [7:0]  m1_awlen, m1_arlen, m1_wstrb;
    logic [2:0]  m1_awsize, m1_arsize;
    logic [1:0]  m1_awburst, m1_arburst, m1_bresp, m1_rresp;
    logic [63:0] m1_wdata, m1_rdata;
    logic s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
    logic s_arvalid, s_arready, s_rvalid, s_rlast, s_rready;
    logic [31:0] s_awaddr, s_araddr;
    logic [3:0]  s_awid, s_arid, s_bid, s_rid;
    logic [7:0]  s_awlen, s_arlen, s_wstrb;
    logic [2:0]  s_awsize, s_arsize;
    logic [1:0]  s_awburst, s_arburst, s_bresp, s_rresp;
    logic [63:0] s_wdata, s_rdata;
    logic busy;

    axi_arbiter #(.ADDR_W(32), .DATA_W(64), .ID_W(4)) dut (
        .clk(clk), .rst(rst),
        .m0_awvalid(m0_awvalid), .m0_awaddr(m0_awaddr), .m0_awid(m0_awid), .m0_awlen(m0_awlen),
        .m0_awsize(m0_awsize), .m0_awburst(m0_awburst), .m0_awready(m0_awready),
        .m0_wvalid(m0_wvalid), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wlast(m0_wlast),
        .m0_wready(m0_wready), .m0_bvalid(m0_bvalid), .m0_bresp(m0_bresp), .m0_bid(m0_bid),
        .m0_bready(m0_bready), .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arid(m0_arid),
        .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst), .m0_arready(m0_arready),
        .m0_rvalid(m0_rvalid), .m0_rresp(m0_rresp), .m0_rdata(m0_rdata), .m0_rlast(m0_rlast),
        .m0_rid(m0_rid), .m0_rready(m0_rready),
        .m1_awvalid(m1_awvalid), .m1_awaddr(m1_awaddr), .m1_awid(m1_awid), .m1_awlen(m1_awlen),
        .m1_awsize(m1_awsize), .m1_awburst(m1_awburst), .m1_awready(m1_awready),
        .m1_wvalid(m1_wvalid), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast),
        .m1_wready(m1_wready), .m1_bvalid(m1_bvalid), .m1_bresp(m1_bresp), .m1_bid(m1_bid),
        .m1_bready(m1_bready), .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arid(m1_arid),
        .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst), .m1_arready(m1_arready),
        .m1_rvalid(m1_rvalid), .m1_rresp(m1_rresp), .m1_rdata(m1_rdata), .m1_rlast(m1_rlast),
        .m1_rid(m1_rid), .m1_rready(m1_rready),
        .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awid(s_awid), .s_awlen(s_awlen),
        .s_awsize(s_awsize), .s_awburst(s_awburst), .s_awready(s_awready),
        .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_wready(s_wready), .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bid(s_bid),
        .s_bready(s_bready), .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arid(s_arid),
        .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rresp(s_rresp), .s_rdata(s_rdata), .s_rlast(s_rlast),
        .s_rid(s_rid), .s_rready(s_rready),
        .busy(busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] data_fn(input logic [31:0] a, input logic [7:0] b);
        if (a == 32'h8000_0000 && b == 8'd0) return 64'h0000_0013_0000_0093;
        return {a, 16'hA5A5, b, 8'h3C};
    endfunction

    // ---------------- slave model ----------------
    logic        rd_active, gap_en, gap_ok, b_pend;
    logic [31:0] rd_addr;
    logic [7:0]  rd_len, rd_beat;
    logic [3:0]  rd_id, wr_id;
    logic [1:0]  resp_cfg;

    assign s_arready = 1'b1;
    assign s_awready = 1'b1;
    assign s_wready  = 1'b1;
    assign s_rvalid  = rd_active && (!gap_en || gap_ok);
    assign s_rdata   = data_fn(rd_addr, rd_beat);
    assign s_rlast   = (rd_beat == rd_len);
    assign s_rid     = rd_id;
    assign s_rresp   = 2'b00;
    assign s_bvalid  = b_pend;
    assign s_bresp   = resp_cfg;
    assign s_bid     = wr_id;

    always @(posedge clk) begin
        if (rst) begin
            rd_active <= 1'b0; rd_addr <= '0; rd_len <= '0; rd_beat <= '0; rd_id <= '0;
            wr_id <= '0; b_pend <= 1'b0; gap_ok <= 1'b0;
        end else begin
            gap_ok <= 1'($urandom_range(0, 1));
            if (s_arvalid && s_arready) begin
                rd_active <= 1'b1; rd_addr <= s_araddr; rd_len <= s_arlen;
                rd_beat <= '0; rd_id <= s_arid;
            end else if (s_rvalid && s_rready) begin
                rd_beat <= rd_beat + 8'd1;
                if (s_rlast) rd_active <= 1'b0;
            end
            if (s_awvalid && s_awready) wr_id <= s_awid;
            if (s_wvalid && s_wready && s_wlast) b_pend <= 1'b1;
            else if (s_bvalid && s_bready) b_pend <= 1'b0;
        end
    end

    // ---------------- scoreboard ----------------
    logic [4:0]  gq[$];          // expected grant order {is_write, id}
    logic [63:0] rq[2][$];       // expected read beats per master
    logic        rlq[2][$];
    logic [5:0]  bq[2][$];       // expected {bid, bresp}
    logic [63:0] wdq[$];
    logic [7:0]  wsq[$];
    bit post_end;
    int busy_cnt, m1_rv_cnt, idle_run, last_gap;

    task automatic clear_sb();
        gq.delete(); wdq.delete(); wsq.delete();
        for (int m = 0; m < 2; m++) begin rq[m].delete(); rlq[m].delete(); bq[m].delete(); end
        post_end = 0;
    endtask

    task automatic mon_r(input int m, input logic hs, input logic [63:0] d, input logic l);
        logic [63:0] ed;
        logic el;
        if (!hs) return;
        if (rq[m].size() == 0) chk("r_unexpected", 64'(hs), 64'd0);
        else begin
            ed = rq[m].pop_front(); el = rlq[m].pop_front();
            chk(m ? "m1_rdata" : "m0_rdata", d, ed);
            chk("rlast", 64'(l), 64'(el));
            if (l) begin chk("busy_at_last", 64'(busy), 64'd1); post_end = 1; end
        end
    endtask

    task automatic mon_b(input int m, input logic hs, input logic [3:0] id, input logic [1:0] r);
        logic [5:0] e;
        if (!hs) return;
        if (bq[m].size() == 0) chk("b_unexpected", 64'(hs), 64'd0);
        else begin
            e = bq[m].pop_front();
            chk(m ? "m1_bresp" : "m0_bresp", 64'({id, r}), 64'(e));
            chk("busy_at_b", 64'(busy), 64'd1);
            post_end = 1;
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (post_end) begin chk("idle_after_end", 64'(busy), 64'd0); post_end = 0; end
            if (busy) begin
                busy_cnt++;
                if (idle_run > 0) last_gap = idle_run;
                idle_run = 0;
            end else idle_run++;
            if (m1_rvalid) m1_rv_cnt++;
            if (s_arvalid && s_arready) begin
                if (gq.size() == 0) chk("gnt_unexpected", 64'({1'b0, s_arid}), 64'h1F);
                else chk("gnt_ar", 64'({1'b0, s_arid}), 64'(gq.pop_front()));
            end
            if (s_awvalid && s_awready) begin
                if (gq.size() == 0) chk("gnt_unexpected", 64'({1'b1, s_awid}), 64'h1F);
                else chk("gnt_aw", 64'({1'b1, s_awid}), 64'(gq.pop_front()));
            end
            if (s_wvalid && s_wready) begin
                if (wdq.size() == 0) chk("w_unexpected", 64'(s_wvalid), 64'd0);
                else begin
                    chk("wdata", s_wdata, wdq.pop_front());
                    chk("wstrb", 64'(s_wstrb), 64'(wsq.pop_front()));
                    chk("wlast", 64'(s_wlast), 64'd1);
                end
            end
            mon_r(0, m0_rvalid && m0_rready, m0_rdata, m0_rlast);
            mon_r(1, m1_rvalid && m1_rready, m1_rdata, m1_rlast);
            mon_b(0, m0_bvalid && m0_bready, m0_bid, m0_bresp);
            mon_b(1, m1_bvalid && m1_bready, m1_bid, m1_bresp);
        end
    end

    // ---------------- master drivers ----------------
    task automatic idle_masters();
        m0_awvalid = 0; m0_awaddr = '0; m0_awid = '0; m0_awlen = '0; m0_awsize = 3'd3; m0_awburst = 2'd1;
        m0_wvalid = 0; m0_wdata = '0; m0_wstrb = '0; m0_wlast = 0; m0_bready = 1;
        m0_arvalid = 0; m0_araddr = '0; m0_arid = '0; m0_arlen = '0; m0_arsize = 3'd3; m0_arburst = 2'd1;
        m0_rready = 1;
        m1_awvalid = 0; m1_awaddr = '0; m1_awid = '0; m1_awlen = '0; m1_awsize = 3'd3; m1_awburst = 2'd1;
        m1_wvalid = 0; m1_wdata = '0; m1_wstrb = '0; m1_wlast = 0; m1_bready = 1;
        m1_arvalid = 0; m1_araddr = '0; m1_arid = '0; m1_arlen = '0; m1_arsize = 3'd3; m1_arburst = 2'd1;
        m1_rready = 1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1; idle_masters();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        clear_sb();
    endtask

    task automatic wait_rq(input int m, input int sz);
        int n = 0;
        while (rq[m].size() > sz && n < 400) begin @(negedge clk); #1; n++; end
        if (rq[m].size() > sz) chk("r_timeout", 64'(rq[m].size()), 64'(sz));
    endtask

    task automatic issue_ar(input int m, input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
        int n = 0;
        logic rdy = 0;
        for (int b = 0; b <= int'(len); b++) begin
            rq[m].push_back(data_fn(a, 8'(b)));
            rlq[m].push_back(b == int'(len));
        end
        @(posedge clk); #1;
        if (m == 0) begin m0_arvalid = 1; m0_araddr = a; m0_arid = id; m0_arlen = len; end
        else        begin m1_arvalid = 1; m1_araddr = a; m1_arid = id; m1_arlen = len; end
        while (!rdy && n < 400) begin
            @(negedge clk); n++;
            rdy = (m == 0) ? m0_arready : m1_arready;
        end
        if (!rdy) chk("ar_timeout", 64'(rdy), 64'd1);
        @(posedge clk); #1;
        if (m == 0) m0_arvalid = 0; else m1_arvalid = 0;
    endtask

    task automatic rd(input int m, input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
        issue_ar(m, a, id, len);
        wait_rq(m, 0);
    endtask

    task automatic wr(input int m, input logic [31:0] a, input logic [3:0] id,
                      input logic [63:0] d, input logic [7:0] s, input logic [1:0] resp);
        int n = 0;
        logic aw_hs, w_hs, aw_on, w_on;
        wdq.push_back(d); wsq.push_back(s);
        bq[m].push_back({id, resp});
        @(posedge clk); #1;
        if (m == 0) begin
            m0_awvalid = 1; m0_awaddr = a; m0_awid = id; m0_awlen = 0;
            m0_wvalid = 1; m0_wdata = d; m0_wstrb = s; m0_wlast = 1;
        end else begin
            m1_awvalid = 1; m1_awaddr = a; m1_awid = id; m1_awlen = 0;
            m1_wvalid = 1; m1_wdata = d; m1_wstrb = s; m1_wlast = 1;
        end
        aw_on = 1; w_on = 1;
        while ((aw_on || w_on) && n < 400) begin
            @(negedge clk); n++;
            aw_hs = aw_on && ((m == 0) ? m0_awready : m1_awready);
            w_hs  = w_on  && ((m == 0) ? m0_wready  : m1_wready);
            @(posedge clk); #1;
            if (aw_hs) begin aw_on = 0; if (m == 0) m0_awvalid = 0; else m1_awvalid = 0; end
            if (w_hs)  begin w_on = 0; if (m == 0) m0_wvalid = 0; else m1_wvalid = 0; end
        end
        if (aw_on || w_on) chk("w_timeout", 64'({aw_on, w_on}), 64'd0);
        n = 0;
        while (bq[m].size() != 0 && n < 400) begin @(negedge clk); #1; n++; end
        if (bq[m].size() != 0) chk("b_timeout", 64'(bq[m].size()), 64'd0);
    endtask

    // ---------------- tests ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; gap_en = 0; resp_cfg = 2'b00;
        busy_cnt = 0; m1_rv_cnt = 0; idle_run = 0; last_gap = 0; post_end = 0;
        idle_masters();
        do_reset();

        // reset state
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_hs", 64'({m0_awready, m0_wready, m0_bvalid, m0_arready, m0_rvalid,
                           m1_awready, m1_wready, m1_bvalid, m1_arready, m1_rvalid,
                           s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready}), 64'd0);
        chk("rst_payload", s_araddr ^ s_awaddr ^ s_wdata ^ m0_rdata ^ m1_rdata, 64'd0);

        // simultaneous IFU read and LSU write
`ifdef AXI_ARB_RR_EN
        gq.push_back({1'b0, 4'd1}); gq.push_back({1'b1, 4'd2});
`else
        gq.push_back({1'b1, 4'd2}); gq.push_back({1'b0, 4'd1});
`endif
        fork
            rd(0, 32'h8000_0040, 4'd1, 8'd0);
            wr(1, 32'h8000_1000, 4'd2, 64'h0000_0000_DEAD_BEEF, 8'h0F, 2'b00);
        join
        chk("tie_idle_gap", 64'(last_gap), 64'd1);
        chk("tie_gq_empty", 64'(gq.size()), 64'd0);

        // single IFU read
        repeat (2) @(negedge clk);
        busy_cnt = 0; m1_rv_cnt = 0;
        gq.push_back({1'b0, 4'd1});
        rd(0, 32'h8000_0000, 4'd1, 8'd0);
        chk("single_busy_cycles", 64'(busy_cnt), 64'd2);
        chk("single_m1_rvalid", 64'(m1_rv_cnt), 64'd0);

        // continuous contention: 4 IFU reads against 8 LSU reads
        do_reset();
`ifdef AXI_ARB_RR_EN
        for (int i = 0; i < 8; i++) gq.push_back({1'b0, (i % 2 == 0) ? 4'd1 : 4'd2});
        for (int i = 0; i < 4; i++) gq.push_back({1'b0, 4'd2});
`else
        for (int i = 0; i < 8; i++) gq.push_back({1'b0, 4'd2});
        for (int i = 0; i < 4; i++) gq.push_back({1'b0, 4'd1});
`endif
        fork
            for (int i = 0; i < 4; i++) rd(0, 32'h8000_0100 + 32'(i * 8), 4'd1, 8'd0);
            for (int j = 0; j < 8; j++) rd(1, 32'h8000_0200 + 32'(j * 8), 4'd2, 8'd0);
        join
        chk("stress_gq_empty", 64'(gq.size()), 64'd0);

        // 4-beat LSU burst with slave rvalid gaps
        gap_en = 1;
        gq.push_back({1'b0, 4'd2});
        rd(1, 32'h8000_2000, 4'd2, 8'd3);
        gap_en = 0;

        // error response passes through, then normal arbitration
        resp_cfg = 2'b10;
        gq.push_back({1'b1, 4'd2});
        wr(1, 32'h8000_3000, 4'd2, 64'h0123_4567_89AB_CDEF, 8'hFF, 2'b10);
        resp_cfg = 2'b00;
        gq.push_back({1'b0, 4'd1});
        rd(0, 32'h8000_0080, 4'd1, 8'd1);

        // reset in the middle of an R burst
        gq.push_back({1'b0, 4'd2});
        issue_ar(1, 32'h8000_4000, 4'd2, 8'd3);
        wait_rq(1, 2);
        rst = 1;
        @(negedge clk);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_hs", 64'({m0_awready, m0_wready, m0_bvalid, m0_arready, m0_rvalid,
                              m1_awready, m1_wready, m1_bvalid, m1_arready, m1_rvalid,
                              s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready}), 64'd0);
        chk("midrst_rdata", m1_rdata, 64'd0);
        @(posedge clk); #1;
        rst = 0;
        clear_sb();
        gq.push_back({1'b0, 4'd1});
        rd(0, 32'h8000_0000, 4'd1, 8'd0);
        chk("final_gq_empty", 64'(gq.size()), 64'd0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_arbiter.md
# axi_arbiter

Two-to-one AXI4 master arbiter that shares the core's single AXI memory port between the instruction fetch unit (master 0) and the load/store unit (master 1). One transaction is outstanding at a time: a read (AR then R until `rlast`) or a write (AW, W, then B). The winning master is connected straight through to the downstream slave until that transaction completes. Sits between IFU/LSU and the crossbar/SRAM.

## Interface
Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 64: data width; `wstrb` is `DATA_W/8`.
- `ID_W`, default 4: ID width.

Ports (`mN_` is master N, N=0 is IFU, N=1 is LSU; `s_` is downstream):
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `mN_awvalid`, `mN_awaddr`, `mN_awid`, `mN_awlen`, `mN_awsize`, `mN_awburst`  in  1/ADDR_W/ID_W/8/3/2  write address request.
- `mN_awready`  out  1  write address accept.
- `mN_wvalid`, `mN_wdata`, `mN_wstrb`, `mN_wlast`  in  1/DATA_W/DATA_W/8/1  write data.
- `mN_wready`  out  1  write data accept.
- `mN_bvalid`, `mN_bresp`, `mN_bid`  out  1/2/ID_W  write response.
- `mN_bready`  in  1  write response accept.
- `mN_arvalid`, `mN_araddr`, `mN_arid`, `mN_arlen`, `mN_arsize`, `mN_arburst`  in  1/ADDR_W/ID_W/8/3/2  read address request.
- `mN_arready`  out  1  read address accept.
- `mN_rvalid`, `mN_rresp`, `mN_rdata`, `mN_rlast`, `mN_rid`  out  1/2/DATA_W/1/ID_W  read data.
- `mN_rready`  in  1  read data accept.
- `s_*`: the same channel set with directions reversed, driven from the granted master.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- The FSM has three states: IDLE, RD, WR. Registers are `state` and `owner` (1 bit); with round-robin, also `last` (1 bit).
- **IDLE**
  - A requester is a master with `arvalid` or `awvalid` high.
  - Select the owner by the priority rule (see Configuration).
  - If the selected owner asserts `arvalid`, go to RD. Otherwise go to WR.
  - If one master asserts both `arvalid` and `awvalid`, the read is served first.
  - In IDLE no channel is connected. All `s_*valid`/`s_*ready` and all `mN_*ready`/`mN_*valid` outputs are 0.
- **RD**
  - AR and R channels are connected combinationally between `m[owner]` and `s_`.
  - All other channels of both masters are held at ready/valid 0.
  - Payload outputs to the non-owner and to unused channels are 0.
  - Exit to IDLE on the cycle after `s_rvalid & s_rready & s_rlast`.
- **WR**
  - AW, W, and B channels are connected to `m[owner]`.
  - Exit to IDLE on the cycle after `s_bvalid & s_bready`.
  - A `bresp` of SLVERR or DECERR is passed through unchanged.
- The arbiter never alters IDs, lengths, or data. Burst length is honoured through `rlast`/`wlast` pass-through.
- Reset mid-transaction: state goes to IDLE and every output valid/ready drops to 0 on the next edge. The in-flight transaction is abandoned. The downstream slave is reset by the same `rst`.

## Timing
- Reset values:
  - `state`=IDLE, `owner`=0, `last`=1 (so master 0 wins the first round-robin tie), `busy`=0.
  - All ready/valid outputs are 0 and all payload outputs are 0.
- Arbitration latency: a request seen in IDLE at edge k is granted at edge k+1. `s_arvalid`/`s_awvalid` first appear in the cycle after k+1.
- Handshake propagation is combinational from grant through transaction end, so there is no added latency per beat.
- Between back-to-back transactions there is exactly one IDLE cycle.
- A master must hold `valid` and its payload stable until `ready` (AXI rule). The arbiter relies on this during the IDLE→grant cycle.
- Both masters requesting on the same edge: the priority rule decides. The loser's `arready`/`awready` stay 0 until it is granted.
- `busy` is registered and equals `state != IDLE`.

## Configuration
- `AXI_ARB_RR_EN` defined: round-robin. On a tie the winner is `~last`. `last` is updated to `owner` when a transaction completes.
- `AXI_ARB_RR_EN` undefined: fixed priority, with master 1 (LSU) always winning ties. The `last` register is not built.

## Test plan
- Single IFU read, addr 0x8000_0000, rdata 0x0000_0013_0000_0093 → `m0_rdata` matches, `m1_rvalid`=0 throughout, `busy` high for exactly the grant..`rlast` cycles.
- IFU read and LSU write (addr 0x8000_1000, wdata 0xDEAD_BEEF, wstrb 0x0F) requested on the same cycle:
  - without the macro, the LSU write completes first (B seen), then the IFU read, with one IDLE cycle between;
  - with the macro, the IFU goes first.
- Round-robin stress: both masters request continuously for 8 transactions → grants alternate 0,1,0,1…; without the macro all 8 go to master 1 while it keeps requesting.
- 4-beat LSU burst read (arlen=3) with slave `rvalid` gaps → 4 beats delivered in order, exit only after the beat with `rlast`=1.
- Slave asserts `bresp`=2'b10 → `m1_bresp`=2'b10; next request arbitrates normally.
- `rst` asserted mid-R burst (after beat 1) → next cycle `state`=IDLE, all valids/readies 0; a fresh IFU read afterwards completes.
